// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, forward-select codes and control-bit positions
package cpu_pkg;
  localparam int WORD_W    = 16;
  localparam int REG_IDX_W = 3;
  localparam int NUM_REGS  = 8;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_ALU = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam int SIG_SRC1     = 4;
  localparam int SIG_SRC2     = 3;
  localparam int SIG_REGDST   = 2;
  localparam int SIG_EXTOP    = 1;
  localparam int SIG_EXTPLACE = 0;

  // ExtPlace moves the byte to the upper half; otherwise ExtOp picks sign vs zero extension
  function automatic logic [WORD_W-1:0] extend_imm(input logic [7:0] imm,
                                                   input logic ext_op,
                                                   input logic ext_place);
    if (ext_place) return {imm, 8'h00};
    return {{8{ext_op & imm[7]}}, imm};
  endfunction
endpackage

// File: rtl/decode_stage_regfile.sv
// rtl/decode_stage_regfile.sv - 8x16 register file, R0 hardwired to zero
module regfile
  import cpu_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_we,
  input  logic [REG_IDX_W-1:0] i_waddr,
  input  logic [WORD_W-1:0]    i_wdata,
  input  logic [REG_IDX_W-1:0] i_raddr_a,
  input  logic [REG_IDX_W-1:0] i_raddr_b,
  output logic [WORD_W-1:0]    o_rdata_a,
  output logic [WORD_W-1:0]    o_rdata_b,
  output logic [WORD_W-1:0]    o_r7
);
  logic [WORD_W-1:0] r_regs [NUM_REGS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_regs <= '{default: '0};
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // No write-to-read bypass: the forwarding mux covers same-cycle write-back
  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];
  assign o_r7      = r_regs[NUM_REGS-1];
endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: index select, extender, forwarding, ID/EX registers, compare
module decode_stage
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 WB_signals,
  input  logic [REG_IDX_W-1:0] DestinationRegister,
  input  logic [WORD_W-1:0]    WBResult,
  input  logic [1:0]           ForwardA,
  input  logic [1:0]           ForwardB,
  input  logic [WORD_W-1:0]    AluResult,
  input  logic [WORD_W-1:0]    MemoryResult,
  input  logic [4:0]           signals,
  input  logic [WORD_W-1:0]    instruction,
  input  logic [WORD_W-1:0]    NPC,
  output logic [REG_IDX_W-1:0] RA,
  output logic [REG_IDX_W-1:0] RB,
  output logic [REG_IDX_W-1:0] TargetDestinationRegister,
  output logic [WORD_W-1:0]    A,
  output logic [WORD_W-1:0]    B,
  output logic [WORD_W-1:0]    I_TypeImmediate,
  output logic [WORD_W-1:0]    J_TypeImmediate,
  output logic [WORD_W-1:0]    ReturnAddress,
  output logic [WORD_W-1:0]    PC1,
  output logic [WORD_W-1:0]    Immediate1,
  output logic                 gt,
  output logic                 lt,
  output logic                 eq
);
  logic [REG_IDX_W-1:0] w_src_a, w_src_b, w_dst;
  logic [WORD_W-1:0]    w_ext, w_rf_a, w_rf_b, w_r7, w_opnd_a, w_opnd_b;
  logic                 w_unused;

  logic [REG_IDX_W-1:0] r_ra, r_rb, r_td;
  logic [WORD_W-1:0]    r_a, r_b, r_iimm, r_jimm, r_ret, r_pc1, r_imm1;

  assign w_src_a  = signals[SIG_SRC1]   ? '0 : instruction[8:6];
  assign w_src_b  = signals[SIG_SRC2]   ? instruction[5:3] : instruction[11:9];
  assign w_dst    = signals[SIG_REGDST] ? 3'd7 : instruction[11:9];
  assign w_ext    = extend_imm(instruction[7:0], signals[SIG_EXTOP], signals[SIG_EXTPLACE]);
  // Opcode bits are decoded upstream
  assign w_unused = ^instruction[15:12];

  regfile u_regfile (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_we     (WB_signals),
    .i_waddr  (DestinationRegister),
    .i_wdata  (WBResult),
    .i_raddr_a(w_src_a),
    .i_raddr_b(w_src_b),
    .o_rdata_a(w_rf_a),
    .o_rdata_b(w_rf_b),
    .o_r7     (w_r7)
  );

  always_comb begin
    w_opnd_a = w_rf_a;
    case (ForwardA)
      FWD_ALU: w_opnd_a = AluResult;
      FWD_MEM: w_opnd_a = MemoryResult;
      FWD_WB:  w_opnd_a = WBResult;
      default: w_opnd_a = w_rf_a;
    endcase
    w_opnd_b = w_rf_b;
    case (ForwardB)
      FWD_ALU: w_opnd_b = AluResult;
      FWD_MEM: w_opnd_b = MemoryResult;
      FWD_WB:  w_opnd_b = WBResult;
      default: w_opnd_b = w_rf_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ra   <= '0;
      r_rb   <= '0;
      r_td   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_iimm <= '0;
      r_jimm <= '0;
      r_ret  <= '0;
      r_pc1  <= '0;
      r_imm1 <= '0;
    end else if (!stall) begin
      r_ra   <= w_src_a;
      r_rb   <= w_src_b;
      r_td   <= w_dst;
      r_a    <= w_opnd_a;
      r_b    <= w_opnd_b;
      r_iimm <= w_ext + NPC;
      r_jimm <= {NPC[15:12], instruction[11:0]};
      r_ret  <= w_r7;
      r_pc1  <= NPC;
      r_imm1 <= w_ext;
    end
  end

  assign RA                        = r_ra;
  assign RB                        = r_rb;
  assign TargetDestinationRegister = r_td;
  assign A                         = r_a;
  assign B                         = r_b;
  assign I_TypeImmediate           = r_iimm;
  assign J_TypeImmediate           = r_jimm;
  assign ReturnAddress             = r_ret;
  assign PC1                       = r_pc1;
  assign Immediate1                = r_imm1;

  assign gt = $signed(r_a) > $signed(r_b);
  assign lt = $signed(r_a) < $signed(r_b);
  assign eq = (r_a == r_b);
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage with directed vectors
module tb_decode_stage;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        stall = 0;
  logic        WB_signals = 0;
  logic [2:0]  DestinationRegister = 0;
  logic [15:0] WBResult = 0;
  logic [1:0]  ForwardA = 0, ForwardB = 0;
  logic [15:0] AluResult = 0, MemoryResult = 0;
  logic [4:0]  signals = 0;
  logic [15:0] instruction = 0, NPC = 0;
  logic [2:0]  RA, RB, TargetDestinationRegister;
  logic [15:0] A, B, I_TypeImmediate, J_TypeImmediate, ReturnAddress, PC1, Immediate1;
  logic        gt, lt, eq;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .WB_signals(WB_signals),
    .DestinationRegister(DestinationRegister), .WBResult(WBResult),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .AluResult(AluResult),
    .MemoryResult(MemoryResult), .signals(signals), .instruction(instruction), .NPC(NPC),
    .RA(RA), .RB(RB), .TargetDestinationRegister(TargetDestinationRegister),
    .A(A), .B(B), .I_TypeImmediate(I_TypeImmediate), .J_TypeImmediate(J_TypeImmediate),
    .ReturnAddress(ReturnAddress), .PC1(PC1), .Immediate1(Immediate1),
    .gt(gt), .lt(lt), .eq(eq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [2:0]  ra, rb, td;
    logic [15:0] a, b, ii, jj, ret, pc1, imm1;
    logic [2:0]  cmp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%04h expected 0x%04h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops every expectation that has come due and compares it against the outputs
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("RA", {13'b0, RA}, {13'b0, e.ra});
      chk("RB", {13'b0, RB}, {13'b0, e.rb});
      chk("TDR", {13'b0, TargetDestinationRegister}, {13'b0, e.td});
      chk("A", A, e.a);
      chk("B", B, e.b);
      chk("I_Imm", I_TypeImmediate, e.ii);
      chk("J_Imm", J_TypeImmediate, e.jj);
      chk("RetAddr", ReturnAddress, e.ret);
      chk("PC1", PC1, e.pc1);
      chk("Imm1", Immediate1, e.imm1);
      chk("gt_lt_eq", {13'b0, gt, lt, eq}, {13'b0, e.cmp});
    end
  end

  task automatic dv(input logic [4:0] sg, input logic [15:0] ins, input logic [15:0] np,
                    input logic [1:0] fa, input logic [1:0] fb,
                    input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] wbr,
                    input logic we, input logic [2:0] dst, input logic st);
    signals = sg; instruction = ins; NPC = np;
    ForwardA = fa; ForwardB = fb; AluResult = alu; MemoryResult = mem;
    WBResult = wbr; WB_signals = we; DestinationRegister = dst; stall = st;
  endtask

  task automatic ex(input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] td,
                    input logic [15:0] a, input logic [15:0] b, input logic [15:0] ii,
                    input logic [15:0] jj, input logic [15:0] ret, input logic [15:0] pc1,
                    input logic [15:0] imm1, input logic [2:0] cmp, input int lag);
    exp_t e;
    e.due = cyc + lag; e.ra = ra; e.rb = rb; e.td = td; e.a = a; e.b = b;
    e.ii = ii; e.jj = jj; e.ret = ret; e.pc1 = pc1; e.imm1 = imm1; e.cmp = cmp;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0);
    tick();
    rst_n = 1;
    // Basic decode while writing R4 in the same edge (old value read)
    dv(5'b00000, 16'h0323, 16'h0002, 0, 0, 0, 0, 16'h0008, 1, 4, 0);
    ex(4, 1, 1, 16'h0000, 16'h0000, 16'h0025, 16'h0323, 0, 16'h0002, 16'h0023, 3'b001, 1); tick();
    dv(5'b00000, 16'h0323, 16'h0002, 0, 0, 0, 0, 0, 0, 0, 0);
    ex(4, 1, 1, 16'h0008, 16'h0000, 16'h0025, 16'h0323, 0, 16'h0002, 16'h0023, 3'b100, 1); tick();
    dv(5'b00000, 16'h0323, 16'h0002, 1, 0, 16'h000A, 0, 0, 0, 0, 0);
    ex(4, 1, 1, 16'h000A, 16'h0000, 16'h0025, 16'h0323, 0, 16'h0002, 16'h0023, 3'b100, 1); tick();
    dv(5'b00000, 16'h0323, 16'h0002, 1, 2, 16'h000A, 16'h000C, 0, 0, 0, 0);
    ex(4, 1, 1, 16'h000A, 16'h000C, 16'h0025, 16'h0323, 0, 16'h0002, 16'h0023, 3'b010, 1); tick();
    dv(5'b00000, 16'h0323, 16'h0002, 3, 2, 0, 16'h000C, 16'h000E, 0, 0, 0);
    ex(4, 1, 1, 16'h000E, 16'h000C, 16'h0025, 16'h0323, 0, 16'h0002, 16'h0023, 3'b100, 1); tick();
    // Index selection
    dv(5'b11010, 16'h0331, 16'h0002, 0, 0, 0, 0, 0, 0, 0, 0);
    ex(0, 6, 1, 16'h0000, 16'h0000, 16'h0033, 16'h0331, 0, 16'h0002, 16'h0031, 3'b001, 1); tick();
    dv(5'b00100, 16'h0331, 16'h0002, 0, 0, 0, 0, 0, 0, 0, 0);
    ex(4, 1, 7, 16'h0008, 16'h0000, 16'h0033, 16'h0331, 0, 16'h0002, 16'h0031, 3'b100, 1); tick();
    // Extender modes and I-type wrap
    dv(5'b00010, 16'h00F0, 16'h0010, 0, 0, 0, 0, 0, 0, 0, 0);
    ex(3, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h00F0, 0, 16'h0010, 16'hFFF0, 3'b001, 1); tick();
    dv(5'b00000, 16'h00F0, 16'h0010, 0, 0, 0, 0, 0, 0, 0, 0);
    ex(3, 0, 0, 16'h0000, 16'h0000, 16'h0100, 16'h00F0, 0, 16'h0010, 16'h00F0, 3'b001, 1); tick();
    dv(5'b00001, 16'h00F0, 16'h0010, 0, 0, 0, 0, 0, 0, 0, 0);
    ex(3, 0, 0, 16'h0000, 16'h0000, 16'hF010, 16'h00F0, 0, 16'h0010, 16'hF000, 3'b001, 1); tick();
    // R0 write ignored, R7 write feeds ReturnAddress one edge later
    dv(5'b00000, 16'h0000, 16'h0020, 0, 0, 0, 0, 16'h1234, 1, 0, 0);
    ex(0, 0, 0, 16'h0000, 16'h0000, 16'h0020, 16'h0000, 0, 16'h0020, 16'h0000, 3'b001, 1); tick();
    dv(5'b00000, 16'h0000, 16'h0020, 0, 0, 0, 0, 16'hBEEF, 1, 7, 0);
    ex(0, 0, 0, 16'h0000, 16'h0000, 16'h0020, 16'h0000, 0, 16'h0020, 16'h0000, 3'b001, 1); tick();
    dv(5'b00000, 16'h0000, 16'h0020, 1, 2, 16'h8000, 16'h0001, 0, 0, 0, 0);
    ex(0, 0, 0, 16'h8000, 16'h0001, 16'h0020, 16'h0000, 16'hBEEF, 16'h0020, 16'h0000, 3'b010, 1); tick();
    // Stall holds outputs; write-back continues
    dv(5'b00000, 16'h0323, 16'h0040, 0, 0, 0, 0, 16'h5555, 1, 5, 1);
    ex(0, 0, 0, 16'h8000, 16'h0001, 16'h0020, 16'h0000, 16'hBEEF, 16'h0020, 16'h0000, 3'b010, 1); tick();
    dv(5'b00000, 16'hFFFF, 16'h0040, 0, 0, 0, 0, 0, 0, 0, 1);
    ex(0, 0, 0, 16'h8000, 16'h0001, 16'h0020, 16'h0000, 16'hBEEF, 16'h0020, 16'h0000, 3'b010, 1); tick();
    dv(5'b00000, 16'h0140, 16'h0040, 0, 0, 0, 0, 0, 0, 0, 0);
    ex(5, 0, 0, 16'h5555, 16'h0000, 16'h0080, 16'h0140, 16'hBEEF, 16'h0040, 16'h0040, 3'b100, 1); tick();
    dv(5'b00000, 16'h0323, 16'h0060, 0, 0, 0, 0, 0, 0, 0, 1);
    ex(5, 0, 0, 16'h5555, 16'h0000, 16'h0080, 16'h0140, 16'hBEEF, 16'h0040, 16'h0040, 3'b100, 1); tick();
    // Asynchronous reset mid-stall, checked before the next rising edge
    @(negedge clk); #1;
    tick();
    #1 rst_n = 0;
    ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0);
    tick();
    rst_n = 1;
    dv(5'b00000, 16'h0140, 16'h0040, 0, 0, 0, 0, 0, 0, 0, 0);
    ex(5, 0, 0, 16'h0000, 16'h0000, 16'h0080, 16'h0140, 16'h0000, 16'h0040, 16'h0040, 3'b001, 1); tick();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
